// File: rtl/dp_share_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : dp_share_arb_if
// Description : Bundles the requester handshake, the shared-datapath issue and
//               return path, and the tagged result bus of dp_share_arb.
// Revision    : 1.0 - initial release
// ============================================================================
interface dp_share_arb_if #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int IW = $clog2(N)
);
    // Requester side
    logic [N-1:0]    i_req;
    logic [N*DW-1:0] i_data;
    logic [N-1:0]    o_gnt;

    // Shared datapath side
    logic [DW-1:0]   o_dp_data;
    logic            o_dp_vld;
    logic [DW-1:0]   i_dp_y;

    // Tagged result side
    logic [DW-1:0]   o_y;
    logic            o_y_vld;
    logic [IW-1:0]   o_y_id;

    // Arbiter view
    modport slave (
        input  i_req, i_data, i_dp_y,
        output o_gnt, o_dp_data, o_dp_vld, o_y, o_y_vld, o_y_id
    );

    // Producer/datapath/consumer view
    modport master (
        output i_req, i_data, i_dp_y,
        input  o_gnt, o_dp_data, o_dp_vld, o_y, o_y_vld, o_y_id
    );
endinterface
`default_nettype wire

// File: rtl/dp_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : dp_share_arb
// Description : Round-robin arbiter sharing one fixed-latency datapath among
//               N requesters. Ownership is held for bursts of up to BURST
//               beats; each issued beat carries its requester id through a
//               latency-matched pipe so results come back tagged.
// Revision    : 1.0 - initial release
// ============================================================================
module dp_share_arb #(
    parameter int N     = 4,
    parameter int DW    = 8,
    parameter int LAT   = 1,
    parameter int BURST = 4,
    parameter int IW    = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    dp_share_arb_if.slave bus
);

    localparam int c_CW = 4;   // holds beat counts up to 15

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   w_ptr_nxt;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   w_owner_nxt;
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] w_cnt_nxt;

    logic [IW-1:0]   w_base;
    logic [IW-1:0]   w_idx;
    logic [IW-1:0]   w_win;
    logic            w_found;
    logic [IW-1:0]   w_gnt_id;
    logic            w_gnt_any;
    logic [N-1:0]    w_gnt;

    logic [DW-1:0]   r_dp_data;
    logic            r_dp_vld;
    logic [LAT:0]    r_pipe_vld;
    logic [IW-1:0]   r_pipe_id [LAT+1];
    logic [DW-1:0]   r_y;
    logic            r_y_vld;
    logic [IW-1:0]   r_y_id;

    // Increment an index modulo N (N need not be a power of two)
    function automatic logic [IW-1:0] f_inc(input logic [IW-1:0] x);
        if (x == IW'(N - 1)) begin
            return '0;
        end
        return x + IW'(1);
    endfunction

    // Priority search upward from the rotating base; in BUSY the base is the
    // slot after the owner, which is only consumed when the owner drops
    always_comb begin
        w_base  = (r_state == S_BUSY) ? f_inc(r_owner) : r_ptr;
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = w_base;
        for (int i = 0; i < N; i++) begin
            if (!w_found && bus.i_req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
            w_idx = f_inc(w_idx);
        end
    end

    // Ownership state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next ownership and grant selection
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        w_gnt_any   = 1'b0;
        w_gnt_id    = r_owner;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_gnt_any   = 1'b1;
                    w_gnt_id    = w_win;
                    w_owner_nxt = w_win;
                    w_cnt_nxt   = c_CW'(1);
                    if (BURST > 1) begin
                        w_state_nxt = S_BUSY;
                    end else begin
                        w_ptr_nxt = f_inc(w_win);
                    end
                end
            end
            S_BUSY: begin
                if (bus.i_req[r_owner]) begin
                    // Owner continues; the BURST-th beat releases the datapath
                    w_gnt_any = 1'b1;
                    w_gnt_id  = r_owner;
                    w_cnt_nxt = r_cnt + c_CW'(1);
                    if (r_cnt >= c_CW'(BURST - 1)) begin
                        w_state_nxt = S_IDLE;
                        w_ptr_nxt   = f_inc(r_owner);
                    end
                end else if (w_found) begin
                    // Owner dropped: hand over in the same cycle, no bubble
                    w_gnt_any   = 1'b1;
                    w_gnt_id    = w_win;
                    w_owner_nxt = w_win;
                    w_cnt_nxt   = c_CW'(1);
                    if (BURST <= 1) begin
                        w_state_nxt = S_IDLE;
                        w_ptr_nxt   = f_inc(w_win);
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                    w_ptr_nxt   = f_inc(r_owner);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // One-hot decode of the granted index
    always_comb begin
        w_gnt = '0;
        if (w_gnt_any) begin
            w_gnt[w_gnt_id] = 1'b1;
        end
    end

    assign bus.o_gnt = rst ? '0 : w_gnt;

    // Register the granted beat towards the datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dp_vld  <= 1'b0;
            r_dp_data <= '0;
        end else begin
            r_dp_vld <= w_gnt_any;
            if (w_gnt_any) begin
                r_dp_data <= bus.i_data[w_gnt_id*DW +: DW];
            end
        end
    end

    // Id/valid pipe aligned with the datapath latency; stage 0 tracks o_dp_vld
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_vld <= '0;
            for (int i = 0; i <= LAT; i++) begin
                r_pipe_id[i] <= '0;
            end
        end else begin
            r_pipe_vld   <= {r_pipe_vld[LAT-1:0], w_gnt_any};
            r_pipe_id[0] <= w_gnt_id;
            for (int i = 1; i <= LAT; i++) begin
                r_pipe_id[i] <= r_pipe_id[i-1];
            end
        end
    end

    // Capture the datapath result together with its owner id at the pipe tail
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_vld <= 1'b0;
            r_y     <= '0;
            r_y_id  <= '0;
        end else begin
            r_y_vld <= r_pipe_vld[LAT];
            if (r_pipe_vld[LAT]) begin
                r_y    <= bus.i_dp_y;
                r_y_id <= r_pipe_id[LAT];
            end
        end
    end

    assign bus.o_dp_data = r_dp_data;
    assign bus.o_dp_vld  = r_dp_vld;
    assign bus.o_y       = r_y;
    assign bus.o_y_vld   = r_y_vld;
    assign bus.o_y_id    = r_y_id;

endmodule
`default_nettype wire

// File: tb/tb_dp_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_dp_share_arb
// Description : Self-checking bench for dp_share_arb: directed scenarios with
//               literal expectations plus randomized traffic against a
//               behavioural arbitration model and result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dp_share_arb;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int LAT   = 1;
    localparam int BURST = 4;
    localparam int IW    = 2;
    localparam logic [DW-1:0] c_XOR = 8'h3C;   // datapath model: y = x ^ 3C

    localparam logic [3:0] c_BURST_SEQ [9] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                                               4'b0010, 4'b0010, 4'b0010, 4'b0010,
                                               4'b0001};
    localparam logic [3:0] c_DROP_SEQ [5]  = '{4'b1000, 4'b1000, 4'b1000, 4'b1000,
                                               4'b0001};

    logic clk;
    logic rst;

    dp_share_arb_if #(.N(N), .DW(DW), .IW(IW)) bus ();

    dp_share_arb #(.N(N), .DW(DW), .LAT(LAT), .BURST(BURST), .IW(IW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference datapath: LAT-cycle delay then XOR
    logic [DW-1:0] dq [LAT];
    initial begin
        for (int i = 0; i < LAT; i++) dq[i] = '0;
    end
    always @(posedge clk) begin
        dq[0] <= bus.o_dp_data;
        for (int i = 1; i < LAT; i++) dq[i] <= dq[i-1];
    end
    assign bus.i_dp_y = dq[LAT-1] ^ c_XOR;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + scoreboard ----------------
    typedef struct {
        int            id;
        logic [DW-1:0] d;
        int            t;
    } beat_t;

    beat_t         sb[$];
    int            cyc_n    = 0;
    bit            armed    = 0;
    int            m_owner  = -1;   // -1: nobody owns the datapath
    int            m_used   = 0;    // beats already taken in this ownership
    int            m_ptr    = 0;
    logic          e_dp_vld = 1'b0;
    logic [DW-1:0] e_dp_data = '0;
    int            wt [N];
    int            n_gr  = 0;
    int            n_ret = 0;

    always @(negedge clk) begin : p_check
        int            w;
        int            base;
        int            maxw;
        logic [N-1:0]  eg;
        beat_t         ent;
        cyc_n++;
        if (armed) begin
            chk("dp_vld", bus.o_dp_vld, e_dp_vld);
            if (e_dp_vld) chk("dp_data", bus.o_dp_data, e_dp_data);
            if (bus.o_y_vld === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("y_unexpected", bus.o_y_vld, 0);
                end else begin
                    ent = sb.pop_front();
                    n_ret++;
                    chk("y_id", bus.o_y_id, ent.id);
                    chk("y_data", bus.o_y, ent.d ^ c_XOR);
                    chk("y_cycle", cyc_n, ent.t + 2 + LAT);
                end
            end else if (sb.size() > 0 && cyc_n >= sb[0].t + 2 + LAT) begin
                chk("y_vld_missing", bus.o_y_vld, 1);
                ent = sb.pop_front();
            end
        end

        eg = '0;
        w  = -1;
        if (!rst) begin
            if (m_owner >= 0 && bus.i_req[m_owner]) begin
                w = m_owner;
                m_used++;
            end else begin
                base = (m_owner >= 0) ? (m_owner + 1) % N : m_ptr;
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && bus.i_req[(base + k) % N]) w = (base + k) % N;
                end
                if (w < 0 && m_owner >= 0) begin
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                end else if (w >= 0) begin
                    m_owner = w;
                    m_used  = 1;
                end
            end
            if (w >= 0 && m_used == BURST) begin
                m_ptr   = (w + 1) % N;
                m_owner = -1;
            end
            if (w >= 0) eg[w] = 1'b1;
        end
        chk("gnt", bus.o_gnt, eg);

        maxw = 0;
        for (int k = 0; k < N; k++) begin
            if (!rst && bus.i_req[k] && !eg[k]) wt[k]++;
            else wt[k] = 0;
            if (wt[k] > maxw) maxw = wt[k];
        end
        chk("wait_bound_ok", (maxw <= (N - 1) * BURST), 1);

        if (rst) begin
            e_dp_vld  = 1'b0;
            e_dp_data = '0;
            sb.delete();
            m_owner = -1;
            m_used  = 0;
            m_ptr   = 0;
            n_gr    = 0;
            n_ret   = 0;
            armed   = 1;
        end else if (w >= 0) begin
            e_dp_vld  = 1'b1;
            e_dp_data = bus.i_data[w*DW +: DW];
            ent.id = w;
            ent.d  = e_dp_data;
            ent.t  = cyc_n;
            sb.push_back(ent);
            n_gr++;
        end else begin
            e_dp_vld = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.i_req   = '0;
        step();
        rst         = 1'b0;
    endtask

    initial begin : p_stim
        logic [N-1:0] g;
        logic [N-1:0] r;
        rst        = 1'b1;
        bus.i_req  = '0;
        bus.i_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values and single request
        @(negedge clk);
        chk("rst_dp_vld", bus.o_dp_vld, 0);
        chk("rst_dp_data", bus.o_dp_data, 0);
        chk("rst_y_vld", bus.o_y_vld, 0);
        chk("rst_y", bus.o_y, 0);
        chk("rst_y_id", bus.o_y_id, 0);
        step();
        bus.i_req  = 4'b0010;
        bus.i_data = 32'h0000_A500;
        @(negedge clk); chk("single_gnt", bus.o_gnt, 4'b0010);
        step();
        bus.i_req = '0;
        @(negedge clk); chk("single_dp_data", bus.o_dp_data, 8'hA5);
        chk("single_dp_vld", bus.o_dp_vld, 1);
        step();
        @(negedge clk); chk("single_y_early", bus.o_y_vld, 0);
        step();
        @(negedge clk); chk("single_y_vld", bus.o_y_vld, 1);
        chk("single_y_id", bus.o_y_id, 1);
        chk("single_y", bus.o_y, 8'h99);

        // Burst limit and rotation
        step(); do_reset();
        bus.i_req  = 4'b0011;
        bus.i_data = 32'h4433_2211;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); chk("burst_gnt", bus.o_gnt, c_BURST_SEQ[i]);
            step();
        end

        // Owner drop mid-burst hands over the same cycle
        do_reset();
        bus.i_req = 4'b0100;
        @(negedge clk); chk("drop_own1", bus.o_gnt, 4'b0100);
        step();
        @(negedge clk); chk("drop_own2", bus.o_gnt, 4'b0100);
        step();
        bus.i_req = 4'b1001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); chk("drop_gnt", bus.o_gnt, c_DROP_SEQ[i]);
            step();
        end

        // Wrap-around after owner 3 finishes its burst
        do_reset();
        bus.i_req = 4'b0010;
        repeat (4) begin
            @(negedge clk); chk("wrap_pre1", bus.o_gnt, 4'b0010);
            step();
        end
        bus.i_req = 4'b1000;
        repeat (4) begin
            @(negedge clk); chk("wrap_pre3", bus.o_gnt, 4'b1000);
            step();
        end
        bus.i_req = 4'b0101;
        @(negedge clk); chk("wrap_gnt", bus.o_gnt, 4'b0001);
        step();

        // Reset in flight discards the beat and restarts search at 0
        do_reset();
        bus.i_req = 4'b0100;
        @(negedge clk); chk("mid_gnt", bus.o_gnt, 4'b0100);
        step();
        rst       = 1'b1;
        bus.i_req = 4'b1111;
        @(negedge clk); chk("mid_rst_gnt", bus.o_gnt, 4'b0000);
        step();
        rst       = 1'b0;
        bus.i_req = 4'b1010;
        @(negedge clk); chk("mid_after_gnt", bus.o_gnt, 4'b0010);
        step();
        bus.i_req = '0;
        @(negedge clk); chk("mid_no_y1", bus.o_y_vld, 0);
        step();
        @(negedge clk); chk("mid_no_y2", bus.o_y_vld, 0);
        step();
        @(negedge clk); chk("mid_y_vld", bus.o_y_vld, 1);
        chk("mid_y_id", bus.o_y_id, 1);
        step();

        // Random stress: producers hold ungranted beats
        do_reset();
        r = '0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            g = bus.o_gnt;
            step();
            for (int k = 0; k < N; k++) begin
                if (r[k] && g[k]) begin
                    if ($urandom_range(9) < 7) bus.i_data[k*DW +: DW] = DW'($urandom);
                    else r[k] = 1'b0;
                end else if (!r[k]) begin
                    if ($urandom_range(9) < 4) begin
                        r[k] = 1'b1;
                        bus.i_data[k*DW +: DW] = DW'($urandom);
                    end
                end
            end
            bus.i_req = r;
        end
        bus.i_req = '0;
        repeat (LAT + 6) step();
        @(negedge clk);
        chk("stress_sb_empty", sb.size(), 0);
        chk("stress_all_returned", n_ret, n_gr);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
